// File: rtl/micro_pkg.sv
// Shared types for the micro core's register-file write path.
package micro_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result FIFO with two ordered write ports and one pop; head is combinational, zero-latency read.
// No stall: a write with no free slot (after this cycle's pop) is dropped and pulses ovf_o.
module wb_fifo
    import micro_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr0_vld_i,
    input  wb_entry_t     wr0_dat_i,
    input  logic          wr1_vld_i,
    input  wb_entry_t     wr1_dat_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output wb_entry_t     head_o,
    output logic          ovf_o
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_ptr;
    logic [CW-1:0] count_q, count_d;
    logic [CW:0]   free;
    logic          pop, acc0, acc1;

    always_comb begin
        pop  = pop_i && (count_q != '0);
        // A slot vacated by this cycle's pop is reusable on the same edge.
        free = (CW+1)'(DEPTH) - (CW+1)'(count_q) + (CW+1)'(pop);
        acc0 = wr0_vld_i && (free != '0);
        acc1 = wr1_vld_i && (free > (CW+1)'(acc0));
        wr1_ptr  = wr_ptr_q + AW'(acc0);
        wr_ptr_d = wr1_ptr + AW'(acc1);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc0) mem_q[wr_ptr_q] <= wr0_dat_i;
        if (acc1) mem_q[wr1_ptr]  <= wr1_dat_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign ovf_o   = (wr0_vld_i && !acc0) || (wr1_vld_i && !acc1);

endmodule

// File: rtl/writeback_unit.sv
// Queues ALU/load results and drives the register-file write port, one write per cycle (result valid N -> write N+1).
// Producers honour wb_ready; excess pushes are dropped into sticky ovf. Per-register scoreboard drives decode hazard.
module writeback_unit
    import micro_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              hazard,
    output logic              wb_ready,
    output logic              ovf,
    output logic              RegWrite,
    output logic [REG_AW-1:0] writeReg,
    output logic [XLEN-1:0]   writeData
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          mem_push, alu_push, wr0_vld, wr1_vld, pop, fifo_ovf, sat_ovf;
    wb_entry_t     mem_ent, alu_ent, wr0_dat, head;
    logic [CW-1:0] count;
    logic [31:0]   inc_vec, dec_vec;
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic          ovf_q, ovf_d;

    // The load result is the older instruction, so it takes the first write port.
    assign mem_push = mem_valid && (mem_rd != '0);
    assign alu_push = alu_valid && (alu_rd != '0);
    assign mem_ent  = '{rd: mem_rd, data: mem_data};
    assign alu_ent  = '{rd: alu_rd, data: alu_data};
    assign wr0_vld  = mem_push || alu_push;
    assign wr0_dat  = mem_push ? mem_ent : alu_ent;
    assign wr1_vld  = mem_push && alu_push;
    assign pop      = (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (CLK),
        .rst_n_i   (RST_n),
        .wr0_vld_i (wr0_vld),
        .wr0_dat_i (wr0_dat),
        .wr1_vld_i (wr1_vld),
        .wr1_dat_i (alu_ent),
        .pop_i     (pop),
        .count_o   (count),
        .head_o    (head),
        .ovf_o     (fifo_ovf)
    );

    always_comb begin
        inc_vec = issue_valid ? (32'd1 << issue_rd) : '0;
        dec_vec = pop ? (32'd1 << head.rd) : '0;
        sat_ovf = 1'b0;
        for (int r = 0; r < 32; r++) cnt_d[r] = cnt_q[r];
        // Index 0 is never touched: x0 has no pending writes.
        for (int r = 1; r < 32; r++) begin
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt_q[r] == '1) sat_ovf = 1'b1;
                else                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        ovf_d = ovf_q || fifo_ovf || sat_ovf;
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            ovf_q <= 1'b0;
            for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
        end else begin
            ovf_q <= ovf_d;
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    assign hazard    = ((rs1 != '0) && (cnt_q[rs1] != '0)) ||
                       ((rs2 != '0) && (cnt_q[rs2] != '0));
    assign wb_ready  = (count <= CW'(DEPTH - 2));
    assign ovf       = ovf_q;
    assign RegWrite  = pop;
    assign writeReg  = pop ? head.rd : '0;
    assign writeData = pop ? head.data : '0;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: inputs driven on the falling edge, outputs checked 1ns later.
module tb_writeback_unit;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2;
    logic [31:0] alu_data, mem_data;
    logic        hazard, wb_ready, ovf, RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] rf [32];

    int n_pass  = 0;
    int n_total = 0;

    initial forever #5 CLK = ~CLK;

    writeback_unit #(.DEPTH(4), .CNT_W(3)) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .wb_ready    (wb_ready),
        .ovf         (ovf),
        .RegWrite    (RegWrite),
        .writeReg    (writeReg),
        .writeData   (writeData)
    );

    // External register file fed by the write port.
    always @(posedge CLK) if (RegWrite) rf[writeReg] <= writeData;

    task automatic nxt;
        @(negedge CLK);
    endtask

    task automatic idle;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic test_reset;
        RST_n = 1'b0;
        idle();
        rs1 = 5; rs2 = 7;
        repeat (3) nxt();
        RST_n = 1'b1;
        #1;
        n_total++; if (RegWrite !== 1'b0) $display("FAIL rst_we got=%b exp=0", RegWrite); else n_pass++;
        n_total++; if (writeReg !== 5'd0) $display("FAIL rst_wreg got=%0d exp=0", writeReg); else n_pass++;
        n_total++; if (writeData !== 32'd0) $display("FAIL rst_wdata got=%h exp=0", writeData); else n_pass++;
        n_total++; if (hazard !== 1'b0) $display("FAIL rst_hazard got=%b exp=0", hazard); else n_pass++;
        n_total++; if (wb_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", wb_ready); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL rst_ovf got=%b exp=0", ovf); else n_pass++;
    endtask

    task automatic test_single_alu;
        nxt(); idle(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; #1;
        n_total++; if (RegWrite !== 1'b0) $display("FAIL single_pre_we got=%b exp=0", RegWrite); else n_pass++;
        nxt(); idle(); #1;
        n_total++; if (RegWrite !== 1'b1) $display("FAIL single_we got=%b exp=1", RegWrite); else n_pass++;
        n_total++; if (writeReg !== 5'd5) $display("FAIL single_wreg got=%0d exp=5", writeReg); else n_pass++;
        n_total++; if (writeData !== 32'hDEADBEEF) $display("FAIL single_wdata got=%h exp=deadbeef", writeData); else n_pass++;
        nxt(); #1;
        n_total++; if (RegWrite !== 1'b0) $display("FAIL single_empty got=%b exp=0", RegWrite); else n_pass++;
        n_total++; if (rf[5] !== 32'hDEADBEEF) $display("FAIL single_rf got=%h exp=deadbeef", rf[5]); else n_pass++;
    endtask

    task automatic test_dual;
        nxt(); idle();
        mem_valid = 1; mem_rd = 3; mem_data = 32'h11;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h22;
        #1;
        nxt(); idle(); #1;
        n_total++; if (writeReg !== 5'd3 || writeData !== 32'h11) $display("FAIL dual_first got=x%0d=%h exp=x3=11", writeReg, writeData); else n_pass++;
        nxt(); #1;
        n_total++; if (RegWrite !== 1'b1 || writeData !== 32'h22) $display("FAIL dual_second got=we%b data=%h exp=we1 data=22", RegWrite, writeData); else n_pass++;
        nxt(); #1;
        n_total++; if (RegWrite !== 1'b0) $display("FAIL dual_empty got=%b exp=0", RegWrite); else n_pass++;
        n_total++; if (rf[3] !== 32'h22) $display("FAIL dual_final got=%h exp=22", rf[3]); else n_pass++;
    endtask

    task automatic test_scoreboard;
        nxt(); idle(); issue_valid = 1; issue_rd = 7; rs1 = 7; #1;
        n_total++; if (hazard !== 1'b0) $display("FAIL sb_same_cycle got=%b exp=0", hazard); else n_pass++;
        nxt(); issue_valid = 0; #1;
        n_total++; if (hazard !== 1'b1) $display("FAIL sb_pending got=%b exp=1", hazard); else n_pass++;
        nxt(); alu_valid = 1; alu_rd = 7; alu_data = 32'h77; #1;
        n_total++; if (hazard !== 1'b1) $display("FAIL sb_push got=%b exp=1", hazard); else n_pass++;
        nxt(); alu_valid = 0; #1;
        n_total++; if (RegWrite !== 1'b1 || writeReg !== 5'd7 || hazard !== 1'b1) $display("FAIL sb_write got=we%b x%0d hz%b exp=we1 x7 hz1", RegWrite, writeReg, hazard); else n_pass++;
        nxt(); #1;
        n_total++; if (hazard !== 1'b0) $display("FAIL sb_clear got=%b exp=0", hazard); else n_pass++;
        // Two outstanding writes to x7, observed through rs2.
        nxt(); idle(); issue_valid = 1; issue_rd = 7; rs2 = 7; #1;
        nxt(); #1;
        n_total++; if (hazard !== 1'b1) $display("FAIL sb2_pending got=%b exp=1", hazard); else n_pass++;
        nxt(); issue_valid = 0;
        mem_valid = 1; mem_rd = 7; mem_data = 32'h71;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h72; #1;
        nxt(); idle(); rs2 = 7; #1;
        n_total++; if (writeData !== 32'h71 || hazard !== 1'b1) $display("FAIL sb2_first got=%h hz%b exp=71 hz1", writeData, hazard); else n_pass++;
        nxt(); #1;
        n_total++; if (writeData !== 32'h72 || hazard !== 1'b1) $display("FAIL sb2_second got=%h hz%b exp=72 hz1", writeData, hazard); else n_pass++;
        nxt(); #1;
        n_total++; if (hazard !== 1'b0 || RegWrite !== 1'b0) $display("FAIL sb2_clear got=hz%b we%b exp=hz0 we0", hazard, RegWrite); else n_pass++;
    endtask

    task automatic test_x0;
        nxt(); idle();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        issue_valid = 1; issue_rd = 0; #1;
        n_total++; if (hazard !== 1'b0) $display("FAIL x0_hazard_now got=%b exp=0", hazard); else n_pass++;
        nxt(); idle();
        mem_valid = 1; mem_rd = 0; mem_data = 32'h66;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99; #1;
        n_total++; if (RegWrite !== 1'b0 || hazard !== 1'b0) $display("FAIL x0_dropped got=we%b hz%b exp=we0 hz0", RegWrite, hazard); else n_pass++;
        nxt(); idle(); #1;
        n_total++; if (RegWrite !== 1'b1 || writeReg !== 5'd9 || writeData !== 32'h99) $display("FAIL x0_alu_only got=we%b x%0d=%h exp=we1 x9=99", RegWrite, writeReg, writeData); else n_pass++;
        nxt(); #1;
        n_total++; if (RegWrite !== 1'b0) $display("FAIL x0_empty got=%b exp=0", RegWrite); else n_pass++;
    endtask

    task automatic test_overflow;
        logic [4:0] exp_seq [4];
        exp_seq[0] = 5'd4; exp_seq[1] = 5'd5; exp_seq[2] = 5'd6; exp_seq[3] = 5'd8;
        nxt(); idle(); mem_valid = 1; alu_valid = 1; mem_rd = 1; alu_rd = 2; #1;
        n_total++; if (wb_ready !== 1'b1) $display("FAIL ovf_ready0 got=%b exp=1", wb_ready); else n_pass++;
        nxt(); mem_rd = 3; alu_rd = 4; #1;
        n_total++; if (writeReg !== 5'd1 || wb_ready !== 1'b1) $display("FAIL ovf_c2 got=x%0d rdy%b exp=x1 rdy1", writeReg, wb_ready); else n_pass++;
        nxt(); mem_rd = 5; alu_rd = 6; #1;
        n_total++; if (writeReg !== 5'd2 || wb_ready !== 1'b0) $display("FAIL ovf_three got=x%0d rdy%b exp=x2 rdy0", writeReg, wb_ready); else n_pass++;
        nxt(); mem_rd = 8; alu_rd = 10; #1;
        n_total++; if (writeReg !== 5'd3 || ovf !== 1'b0) $display("FAIL ovf_full got=x%0d ovf%b exp=x3 ovf0", writeReg, ovf); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            nxt(); idle(); #1;
            n_total++; if (RegWrite !== 1'b1 || writeReg !== exp_seq[i]) $display("FAIL ovf_drain%0d got=we%b x%0d exp=we1 x%0d", i, RegWrite, writeReg, exp_seq[i]); else n_pass++;
            n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky%0d got=%b exp=1", i, ovf); else n_pass++;
        end
        nxt(); #1;
        n_total++; if (RegWrite !== 1'b0 || ovf !== 1'b1 || wb_ready !== 1'b1) $display("FAIL ovf_after got=we%b ovf%b rdy%b exp=we0 ovf1 rdy1", RegWrite, ovf, wb_ready); else n_pass++;
    endtask

    task automatic test_reset_mid;
        nxt(); idle(); issue_valid = 1; issue_rd = 20; rs1 = 20;
        mem_valid = 1; mem_rd = 12; alu_valid = 1; alu_rd = 13; #1;
        nxt(); issue_valid = 0; mem_rd = 14; alu_rd = 15; #1;
        n_total++; if (hazard !== 1'b1 || writeReg !== 5'd12) $display("FAIL mid_pre got=hz%b x%0d exp=hz1 x12", hazard, writeReg); else n_pass++;
        nxt(); idle(); rs1 = 20; RST_n = 1'b0; #1;
        n_total++; if (wb_ready !== 1'b0 || RegWrite !== 1'b1) $display("FAIL mid_queued got=rdy%b we%b exp=rdy0 we1", wb_ready, RegWrite); else n_pass++;
        nxt(); RST_n = 1'b1; #1;
        n_total++; if (RegWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0) $display("FAIL mid_port got=we%b x%0d=%h exp=we0 x0=0", RegWrite, writeReg, writeData); else n_pass++;
        n_total++; if (hazard !== 1'b0) $display("FAIL mid_hazard got=%b exp=0", hazard); else n_pass++;
        n_total++; if (wb_ready !== 1'b1 || ovf !== 1'b0) $display("FAIL mid_flags got=rdy%b ovf%b exp=rdy1 ovf0", wb_ready, ovf); else n_pass++;
        nxt(); #1;
        n_total++; if (RegWrite !== 1'b0) $display("FAIL mid_lost got=%b exp=0", RegWrite); else n_pass++;
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 7; i++) begin
            nxt(); idle(); issue_valid = 1; issue_rd = 21; rs1 = 21; #1;
        end
        nxt(); #1;
        n_total++; if (ovf !== 1'b0 || hazard !== 1'b1) $display("FAIL sat_at_max got=ovf%b hz%b exp=ovf0 hz1", ovf, hazard); else n_pass++;
        nxt(); issue_valid = 0; #1;
        n_total++; if (ovf !== 1'b1) $display("FAIL sat_ovf got=%b exp=1", ovf); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            nxt(); alu_valid = 1; alu_rd = 21; alu_data = 32'(i); #1;
        end
        nxt(); idle(); rs1 = 21; #1;
        n_total++; if (hazard !== 1'b1 || RegWrite !== 1'b1 || writeData !== 32'd6) $display("FAIL sat_last got=hz%b we%b data=%h exp=hz1 we1 data=6", hazard, RegWrite, writeData); else n_pass++;
        nxt(); #1;
        n_total++; if (hazard !== 1'b0) $display("FAIL sat_drained got=%b exp=0", hazard); else n_pass++;
        n_total++; if (rf[21] !== 32'd6) $display("FAIL sat_rf got=%h exp=6", rf[21]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_dual();
        test_scoreboard();
        test_x0();
        test_overflow();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
